// File: rtl/voice_allocator.sv
// Voice allocator: maps incoming notes onto a small pool of voices using retrigger, then free, then steal.
// Each voice keeps a beat counter and is released when the count expires.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic [NOTE_W-1:0]            note,
  input  logic [DUR_W-1:0]             duration,
  input  logic                         new_note,
  input  logic                         beat,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [2:0]                   active_count,
  output logic                         stole
);

  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
  logic [NUM_VOICES-1:0][DUR_W-1:0]  cnt_q, cnt_d;
  logic [NUM_VOICES-1:0]             active_q, active_d;
  logic [NUM_VOICES-1:0]             load_q, load_d;
  logic [2:0]                        count_q, count_d;
  logic                              stole_q, stole_d;

  logic accept;
  logic hit, found;
  int   sel;

  assign accept = new_note && (note != '0) && (duration != '0);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    note_d   = note_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    load_d   = '0;
    stole_d  = 1'b0;
    hit      = 1'b0;
    found    = 1'b0;
    sel      = 0;

    // Beat first, so a voice expiring on this beat is free for a same-cycle allocation.
    if (beat && play) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (active_q[i] && cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - DUR_W'(1);
          if (cnt_q[i] == DUR_W'(1)) begin
            active_d[i] = 1'b0;
            note_d[i]   = '0;
          end
        end
      end
    end

    // Retrigger matches the voice that held the note going into this cycle.
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!hit && active_q[i] && note_q[i] == note) begin
        hit = 1'b1;
        sel = i;
      end
    end
    if (!hit) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (!found && !active_d[i]) begin
          found = 1'b1;
          sel   = i;
        end
      end
    end
    if (!hit && !found) begin
      for (int i = 1; i < NUM_VOICES; i++) begin
        if (cnt_d[i] < cnt_d[sel]) sel = i;
      end
    end

    if (accept) begin
      note_d[sel]   = note;
      cnt_d[sel]    = duration;
      active_d[sel] = 1'b1;
      load_d[sel]   = 1'b1;
      stole_d       = !hit && !found;
    end

    count_d = 3'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (active_d[i]) count_d = count_d + 3'd1;
    end
  end

  // NOTE: the per-voice arrays are small registers, not RAM, so they are all cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_q   <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      load_q   <= '0;
      count_q  <= 3'd0;
      stole_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the same pre-edge state.
      note_q   <= note_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      load_q   <= load_d;
      count_q  <= count_d;
      stole_q  <= stole_d;
    end
  end

  assign voice_note   = note_q;
  assign voice_active = active_q;
  assign voice_load   = load_q;
  assign active_count = count_q;
  assign stole        = stole_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator with hand-computed expectations.
module tb_voice_allocator;

  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            play = 1'b1;
  logic [NW-1:0]   note = '0;
  logic [DW-1:0]   duration = '0;
  logic            new_note = 1'b0;
  logic            beat = 1'b0;
  logic [NV*NW-1:0] voice_note;
  logic [NV-1:0]   voice_active;
  logic [NV-1:0]   voice_load;
  logic [2:0]      active_count;
  logic            stole;

  int errors = 0;
  int checks = 0;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
    .clk(clk), .reset(reset), .play(play), .note(note), .duration(duration),
    .new_note(new_note), .beat(beat), .voice_note(voice_note),
    .voice_active(voice_active), .voice_load(voice_load),
    .active_count(active_count), .stole(stole)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int vn(input int i);
    return int'(voice_note[i*NW +: NW]);
  endfunction

  task automatic do_reset();
    reset = 1'b1; new_note = 1'b0; beat = 1'b0; play = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock with the given inputs; returns 1 ns after the edge.
  task automatic tick(input logic nn, input int n, input int d, input logic b);
    new_note = nn; note = NW'(n); duration = DW'(d); beat = b;
    @(posedge clk);
    #1 new_note = 1'b0; beat = 1'b0;
  endtask

  task automatic beats(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 0, 0, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_act"},   voice_active, 0);
    check({tag, "_note"},  voice_note, 0);
    check({tag, "_load"},  voice_load, 0);
    check({tag, "_cnt"},   active_count, 0);
    check({tag, "_stole"}, stole, 0);
  endtask

  initial begin
    // Reset state and single note
    do_reset();
    check_idle("rst");
    tick(1'b1, 37, 4, 1'b0);
    check("s1_act", voice_active, 3'b001);
    check("s1_note0", vn(0), 37);
    check("s1_load", voice_load, 3'b001);
    check("s1_cnt", active_count, 1);
    check("s1_stole", stole, 0);
    tick(1'b0, 0, 0, 1'b0);
    check("s1_load_off", voice_load, 0);
    beats(3);
    check("s1_b3_act", voice_active, 3'b001);
    beats(1);
    check("s1_b4_act", voice_active, 0);
    check("s1_b4_note", vn(0), 0);
    check("s1_b4_cnt", active_count, 0);

    // Three staggered notes expire together
    do_reset();
    tick(1'b1, 37, 4, 1'b0);
    tick(1'b0, 0, 0, 1'b0);
    tick(1'b1, 41, 4, 1'b0);
    check("s2_load1", voice_load, 3'b010);
    tick(1'b0, 0, 0, 1'b0);
    tick(1'b1, 44, 4, 1'b0);
    check("s2_load2", voice_load, 3'b100);
    check("s2_cnt", active_count, 3);
    check("s2_notes", voice_note, (44 << 12) | (41 << 6) | 37);
    beats(3);
    check("s2_b3", voice_active, 3'b111);
    beats(1);
    check("s2_b4", voice_active, 0);
    check("s2_b4_cnt", active_count, 0);

    // Steal the voice with the smallest remaining count (back-to-back loads)
    do_reset();
    tick(1'b1, 37, 4, 1'b0);
    tick(1'b1, 41, 2, 1'b0);
    check("s3_b2b_load", voice_load, 3'b010);
    tick(1'b1, 44, 3, 1'b0);
    check("s3_full", voice_active, 3'b111);
    tick(1'b1, 49, 5, 1'b0);
    check("s3_note1", vn(1), 49);
    check("s3_note0", vn(0), 37);
    check("s3_stole", stole, 1);
    check("s3_load", voice_load, 3'b010);
    check("s3_cnt", active_count, 3);
    tick(1'b0, 0, 0, 1'b0);
    check("s3_stole_off", stole, 0);
    beats(3);
    check("s3_b3", voice_active, 3'b011);
    beats(1);
    check("s3_b4", voice_active, 3'b010);
    beats(1);
    check("s3_b5", voice_active, 0);

    // Retrigger on the beat where the voice would expire
    do_reset();
    tick(1'b1, 37, 1, 1'b0);
    tick(1'b1, 41, 3, 1'b0);
    tick(1'b1, 37, 6, 1'b1);
    check("s4_act", voice_active, 3'b011);
    check("s4_load", voice_load, 3'b001);
    check("s4_stole", stole, 0);
    check("s4_note0", vn(0), 37);
    beats(2);
    check("s4_b2", voice_active, 3'b001);
    beats(3);
    check("s4_b5", voice_active, 3'b001);
    beats(1);
    check("s4_b6", voice_active, 0);

    // Pause freezes the counters
    do_reset();
    tick(1'b1, 37, 2, 1'b0);
    play = 1'b0;
    beats(3);
    check("s5_paused", voice_active, 3'b001);
    play = 1'b1;
    beats(1);
    check("s5_b1", voice_active, 3'b001);
    beats(1);
    check("s5_b2", voice_active, 0);

    // Request filter and asynchronous mid-note reset
    do_reset();
    tick(1'b1, 37, 4, 1'b0);
    tick(1'b1, 41, 0, 1'b0);
    check("s6_dur0_act", voice_active, 3'b001);
    check("s6_dur0_load", voice_load, 0);
    check("s6_dur0_notes", voice_note, 37);
    tick(1'b1, 0, 5, 1'b0);
    check("s6_note0_act", voice_active, 3'b001);
    check("s6_note0_load", voice_load, 0);
    check("s6_note0_stole", stole, 0);
    tick(1'b1, 41, 4, 1'b0);
    check("s6_two", active_count, 2);
    #2 reset = 1'b1;
    #1 check_idle("s6_async");
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1'b0, 0, 0, 1'b0);
    check_idle("s6_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules incoming notes onto a fixed pool of note-player voices for the chords datapath.
- Accepts one note per `new_note` pulse and assigns it to a voice: a retriggered existing voice, a free voice, or a stolen voice.
- Counts each voice's remaining duration in beats and frees the voice when the count expires.
- Drives per-voice note, active and load signals, plus an active-voice count the mixer uses for gain scaling.

Parameters:
- NUM_VOICES, 3, number of voices managed (1..4 supported).
- NOTE_W, 6, note code width; 0 means rest.
- DUR_W, 6, duration width in beats.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- play  in  1  high = durations advance on beat; low = all counts frozen.
- note  in  NOTE_W  note code, sampled when new_note is high.
- duration  in  DUR_W  length in beats, sampled when new_note is high.
- new_note  in  1  single-cycle request to start a note.
- beat  in  1  single-cycle beat tick.
- voice_note  out  NUM_VOICES*NOTE_W  note per voice; voice i occupies bits [i*NOTE_W +: NOTE_W].
- voice_active  out  NUM_VOICES  voice i is currently sounding.
- voice_load  out  NUM_VOICES  one-cycle pulse; voice i must reset phase and load its new note.
- active_count  out  3  population count of voice_active.
- stole  out  1  one-cycle pulse; the last allocation evicted a sounding voice.

Behaviour:
- All outputs and internal per-voice remaining counters are registered.
- On reset (async): voice_note=0, voice_active=0, voice_load=0, active_count=0, stole=0, all counters=0.
- Beat update, evaluated each clock edge with beat=1 and play=1:
  - every active voice decrements its counter by 1;
  - a voice whose counter was 1 goes inactive; its voice_note is cleared to 0.
- When play=0, beats are ignored and counters hold. new_note is still accepted.
- Request filter: a new_note with duration=0 or note=0 is dropped (no state change, no pulses).
- Allocation on an accepted new_note, priority order:
  1. Retrigger: an active voice already holding the same note code reloads its counter with duration. If several match, the lowest index wins.
  2. Free: otherwise take the lowest-index inactive voice.
  3. Steal: otherwise evict the voice with the smallest remaining count (tie: lowest index) and pulse stole.
- Counter loading: the chosen voice's counter is loaded with duration, exactly (the load is not decremented by a same-cycle beat). voice_note is set to note and voice_active to 1.
- Load pulse: voice_load[i] pulses high for exactly the one cycle following the new_note edge, in all three allocation cases, including retrigger.
- Same-cycle new_note and beat:
  - the beat decrement is applied first to all other voices;
  - a voice that expires on this beat counts as free for this allocation.
- Back-to-back new_note pulses on consecutive cycles are each allocated. A later allocation sees the state updated by the earlier one, so there are no lost requests.
- active_count always equals the population count of voice_active, in the same cycle.
- Counter width is DUR_W. Counters never wrap: decrement only occurs when counter>0 and the voice is active.
- Reset asserted mid-note clears all voices immediately; voice_load does not pulse on reset release.
- The block does not consume generate_next_sample; sample timing belongs to the voices.

Test Plan:
- Reset 2 cycles, then note=37, duration=4, new_note pulse:
  - voice 0 active with voice_note=37;
  - voice_load=001 for one cycle;
  - active_count=1;
  - voice 0 goes inactive on the 4th subsequent beat.
- Notes 37, 41, 44 on cycles 0, 2, 4, each duration 4 → voices 0, 1, 2 load in order; active_count reaches 3; all three expire on the same beat.
- All 3 voices busy with remaining 4, 2, 3; new note 49, duration 5 → voice 1 replaced with 49, stole pulses, counter=5, active_count stays 3.
- Voice 0 holds 37 with remaining 1; note 37, duration 6 arrives together with a beat:
  - voice 0 retriggers with counter=6;
  - voice_load[0] pulses;
  - voice 0 never drops inactive.
- play=0 for 3 beats with voice 0 remaining 2 → counter holds at 2. After play=1, voice 0 expires on the 2nd beat.
- Request filter and mid-note reset:
  - new_note with duration=0 → no change, no pulses;
  - new_note with note=0 → no change, no pulses;
  - reset asserted while 2 voices are active → all outputs 0 asynchronously, before the next clk edge.
